// File: rtl/deserializer.sv
// deserializer: rebuilds MSB-first serial bursts into left-aligned parallel
// words. A word completes after DATA_W accepted bits or when the valid strobe
// drops mid-word. Each word is reported with a data_mod count where 0 means
// all DATA_W bits are valid.
// Optional feature: define DESER_PARTIAL_EN to emit partial words at a burst
// end. When it is undefined, partial words are dropped and deser_data_mod_o
// is tied to 0.
module deserializer #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o,
  output logic              busy_o
);

  localparam int CNT_W = MOD_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              val_q, val_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] word_w;
  logic [CNT_W-1:0]  bit_pos_w;

`ifdef DESER_PARTIAL_EN
  logic [MOD_W-1:0]  mod_q, mod_d;
`endif

  // Next-state logic: accept a bit, close a full word, or close a burst.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch); combinational blocks use blocking '='.
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    val_d     = 1'b0;
`ifdef DESER_PARTIAL_EN
    mod_d     = mod_q;
`endif
    // Incoming bit lands at DATA_W-1-cnt so the first bit is the MSB.
    bit_pos_w = LAST_IDX - cnt_q;
    word_w    = sh_q | (DATA_W'(ser_data_i) << bit_pos_w);

    if (ser_data_val_i) begin
      if (cnt_q == LAST_IDX) begin
        // Last bit of the word: publish including the current bit.
        data_d = word_w;
        val_d  = 1'b1;
`ifdef DESER_PARTIAL_EN
        mod_d  = '0;
`endif
        cnt_d  = '0;
        sh_d   = '0;
      end else begin
        sh_d  = word_w;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (cnt_q != '0) begin
      // Burst end: valid dropped while a word was in progress.
`ifdef DESER_PARTIAL_EN
      data_d = sh_q;
      mod_d  = cnt_q[MOD_W-1:0];
      val_d  = 1'b1;
`endif
      cnt_d = '0;
      sh_d  = '0;
    end

    busy_d = (cnt_d != '0);
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk_i or posedge arst_i) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update
    // together from values sampled at the same edge.
    if (arst_i) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      val_q  <= 1'b0;
      busy_q <= 1'b0;
`ifdef DESER_PARTIAL_EN
      mod_q  <= '0;
`endif
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      val_q  <= val_d;
      busy_q <= busy_d;
`ifdef DESER_PARTIAL_EN
      mod_q  <= mod_d;
`endif
    end
  end

  assign deser_data_o     = data_q;
  assign deser_data_val_o = val_q;
  assign busy_o           = busy_q;
`ifdef DESER_PARTIAL_EN
  assign deser_data_mod_o = mod_q;
`else
  assign deser_data_mod_o = '0;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Testbench for deserializer: directed bursts checked every cycle against a
// queue-based model of the word framing rules, plus literal expectations.
module tb_deserializer;

  localparam int DATA_W = 16;
  localparam int MOD_W  = 4;

  logic              clk_i = 1'b0;
  logic              arst_i = 1'b1;
  logic              ser_data_i = 1'b0;
  logic              ser_data_val_i = 1'b0;
  logic [DATA_W-1:0] deser_data_o;
  logic [MOD_W-1:0]  deser_data_mod_o;
  logic              deser_data_val_o;
  logic              busy_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  deserializer #(.DATA_W(DATA_W), .MOD_W(MOD_W)) dut (
    .clk_i            (clk_i),
    .arst_i           (arst_i),
    .ser_data_i       (ser_data_i),
    .ser_data_val_i   (ser_data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_data_mod_o (deser_data_mod_o),
    .deser_data_val_o (deser_data_val_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: queue of accepted bits ----------------
  bit                bits_q[$];
  logic [DATA_W-1:0] exp_data = '0;
  logic [MOD_W-1:0]  exp_mod  = '0;
  logic              exp_val  = 1'b0;
  logic              exp_busy = 1'b0;

  function automatic logic [DATA_W-1:0] pack_bits(input bit q[$]);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < q.size(); i++) w[DATA_W-1-i] = q[i];
    return w;
  endfunction

  initial begin
    forever begin
      @(posedge clk_i or posedge arst_i);
      if (arst_i) begin
        bits_q.delete();
        exp_data = '0; exp_mod = '0; exp_val = 1'b0; exp_busy = 1'b0;
      end else begin
        exp_val = 1'b0;
        if (ser_data_val_i) begin
          bits_q.push_back(ser_data_i);
          if (bits_q.size() == DATA_W) begin
            exp_data = pack_bits(bits_q);
            exp_mod  = '0;
            exp_val  = 1'b1;
            bits_q.delete();
          end
        end else if (bits_q.size() > 0) begin
`ifdef DESER_PARTIAL_EN
          exp_data = pack_bits(bits_q);
          exp_mod  = MOD_W'(bits_q.size());
          exp_val  = 1'b1;
`endif
          bits_q.delete();
        end
        exp_busy = (bits_q.size() != 0);
      end
    end
  end

  // ---------------- per-cycle compare and pulse capture ----------------
  logic [DATA_W-1:0] cap_data[$];
  logic [MOD_W-1:0]  cap_mod[$];
  int                cap_cyc[$];
  int                busy_seen = 0;

  initial begin
    forever begin
      @(negedge clk_i);
      check("val",  32'(deser_data_val_o), 32'(exp_val));
      check("data", 32'(deser_data_o),     32'(exp_data));
      check("mod",  32'(deser_data_mod_o), 32'(exp_mod));
      check("busy", 32'(busy_o),           32'(exp_busy));
      if (deser_data_val_o === 1'b1) begin
        cap_data.push_back(deser_data_o);
        cap_mod.push_back(deser_data_mod_o);
        cap_cyc.push_back(cyc);
      end
      if (busy_o === 1'b1) busy_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_bit(input logic b);
    @(negedge clk_i);
    ser_data_i     = b;
    ser_data_val_i = 1'b1;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      ser_data_val_i = 1'b0;
      ser_data_i     = 1'b0;
    end
  endtask

  task automatic clear_caps();
    @(posedge clk_i);
    #1;
    cap_data.delete(); cap_mod.delete(); cap_cyc.delete();
    busy_seen = 0;
  endtask

  task automatic pulse_reset_mid_cycle();
    @(posedge clk_i);
    #2;
    arst_i         = 1'b1;
    ser_data_val_i = 1'b0;
    #1;
    check("rst_val",  32'(deser_data_val_o), 32'h0);
    check("rst_data", 32'(deser_data_o),     32'h0);
    check("rst_mod",  32'(deser_data_mod_o), 32'h0);
    check("rst_busy", 32'(busy_o),           32'h0);
    @(negedge clk_i);
    arst_i = 1'b0;
  endtask

  initial begin
    #1;
    check("por_data", 32'(deser_data_o), 32'h0);
    check("por_busy", 32'(busy_o),       32'h0);
    repeat (2) @(negedge clk_i);
    arst_i = 1'b0;
    idle(2);

    // Full word 0xA5C3 with val held high.
    clear_caps();
    send_word(16'hA5C3);
    idle(3);
    check("fw_count", 32'(cap_data.size()), 32'd1);
    if (cap_data.size() >= 1) begin
      check("fw_data", 32'(cap_data[0]), 32'hA5C3);
      check("fw_mod",  32'(cap_mod[0]),  32'h0);
    end
    check("fw_busy_cycles", 32'(busy_seen), 32'd15);

    // Asynchronous reset mid-cycle while data is held and a word is busy.
    idle(1);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    pulse_reset_mid_cycle();
    idle(2);

    // Back-to-back words, val never drops between them.
    clear_caps();
    send_word(16'h1234);
    send_word(16'hFFFF);
    idle(3);
    check("b2b_count", 32'(cap_data.size()), 32'd2);
    if (cap_data.size() >= 2) begin
      check("b2b_data0", 32'(cap_data[0]), 32'h1234);
      check("b2b_data1", 32'(cap_data[1]), 32'hFFFF);
      check("b2b_mod1",  32'(cap_mod[1]),  32'h0);
      check("b2b_gap",   32'(cap_cyc[1] - cap_cyc[0]), 32'd16);
    end

    // Partial word: 1,0,1 then val low.
    clear_caps();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    idle(3);
`ifdef DESER_PARTIAL_EN
    check("part_count", 32'(cap_data.size()), 32'd1);
    if (cap_data.size() >= 1) begin
      check("part_data", 32'(cap_data[0]), 32'hA000);
      check("part_mod",  32'(cap_mod[0]),  32'd3);
    end
`else
    check("part_count", 32'(cap_data.size()), 32'd0);
`endif
    check("part_busy_after", 32'(busy_o), 32'h0);

    // Reset mid-word: 9 bits discarded, then a clean 0x0F0F.
    clear_caps();
    for (int i = 0; i < 9; i++) send_bit(1'b1);
    pulse_reset_mid_cycle();
    send_word(16'h0F0F);
    idle(3);
    check("rmw_count", 32'(cap_data.size()), 32'd1);
    if (cap_data.size() >= 1) begin
      check("rmw_data", 32'(cap_data[0]), 32'h0F0F);
      check("rmw_mod",  32'(cap_mod[0]),  32'h0);
    end

    // Idle gap with toggling data and val low.
    clear_caps();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      ser_data_val_i = 1'b0;
      ser_data_i     = i[0];
    end
    idle(2);
    check("idle_count", 32'(cap_data.size()), 32'd0);
    check("idle_busy",  32'(busy_seen),       32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
